// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single-write-port register file.
// Two sources (ALU, LSU) each feed a small in-order FIFO via valid/ready. A
// round-robin arbiter drains one head per cycle into a registered write stage.
// A per-register busy vector reports every buffered or in-flight write.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,

    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,

    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_W-1:0]        lsu_rd,
    input  logic [DATA_W-1:0]        lsu_data,

    output logic [ADDR_W-1:0]        writereg,
    output logic [DATA_W-1:0]        writedata,
    output logic                     regwrite,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int unsigned NumSrc  = 2;
    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam int unsigned CntW    = $clog2(DEPTH + 1);

    // Source index 0 is the ALU, 1 is the LSU.
    typedef enum logic {
        SrcAlu = 1'b0,
        SrcLsu = 1'b1
    } src_e;

    // Per-source views of the request ports so both FIFOs share one description.
    logic [NumSrc-1:0]             in_valid;
    logic [NumSrc-1:0][ADDR_W-1:0] in_rd;
    logic [NumSrc-1:0][DATA_W-1:0] in_data;

    assign in_valid = {lsu_valid, alu_valid};
    assign in_rd    = {lsu_rd, alu_rd};
    assign in_data  = {lsu_data, alu_data};

    // FIFO storage and bookkeeping.
    logic [ADDR_W-1:0]           fifo_rd_q   [NumSrc][DEPTH];
    logic [DATA_W-1:0]           fifo_data_q [NumSrc][DEPTH];
    logic [NumSrc-1:0][PtrW-1:0] wptr_q, wptr_d;
    logic [NumSrc-1:0][PtrW-1:0] rptr_q, rptr_d;
    logic [NumSrc-1:0][CntW-1:0] cnt_q, cnt_d;

    // Write stage and arbitration history.
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] writereg_q, writereg_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    src_e              last_q, last_d;

    logic [NumSrc-1:0] ready;
    logic [NumSrc-1:0] nonempty;
    logic [NumSrc-1:0] push;
    logic [NumSrc-1:0] pop;
    logic              grant_alu;
    logic              grant_lsu;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic [NumRegs-1:0] busy_vec;

    // Handshake: ready only when out of reset and not full (no pop-through).
    // Writes to x0 complete the handshake but are never stored.
    always_comb begin
        ready    = '0;
        nonempty = '0;
        push     = '0;
        for (int s = 0; s < int'(NumSrc); s++) begin
            ready[s]    = reset_n && (cnt_q[s] != CntW'(DEPTH));
            nonempty[s] = (cnt_q[s] != '0);
            push[s]     = in_valid[s] && ready[s] && (in_rd[s] != '0);
        end
    end

    assign alu_ready = ready[0];
    assign lsu_ready = ready[1];

    // Round-robin: a lone non-empty source wins; on a tie the source that did
    // not win last time wins.
    always_comb begin
        grant_alu = nonempty[0] && (!nonempty[1] || (last_q == SrcLsu));
        grant_lsu = nonempty[1] && !grant_alu;
        pop       = {grant_lsu, grant_alu};
        head_rd   = grant_alu ? fifo_rd_q[0][rptr_q[0]]   : fifo_rd_q[1][rptr_q[1]];
        head_data = grant_alu ? fifo_data_q[0][rptr_q[0]] : fifo_data_q[1][rptr_q[1]];
    end

    // FIFO pointer and occupancy next state; pointers wrap since DEPTH is 2**n.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        for (int s = 0; s < int'(NumSrc); s++) begin
            wptr_d[s] = wptr_q[s] + PtrW'(push[s]);
            rptr_d[s] = rptr_q[s] + PtrW'(pop[s]);
            cnt_d[s]  = cnt_q[s] + CntW'(push[s]) - CntW'(pop[s]);
        end
    end

    // Write stage next state: a grant loads the head; otherwise address/data hold.
    always_comb begin
        regwrite_d  = grant_alu || grant_lsu;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        last_d      = last_q;
        if (grant_alu || grant_lsu) begin
            writereg_d  = head_rd;
            writedata_d = head_data;
            last_d      = grant_alu ? SrcAlu : SrcLsu;
        end
    end

    // FIFO control registers, cleared by reset so buffered writes are dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage; contents only matter where the occupancy count says so.
    always_ff @(posedge clock) begin
        for (int s = 0; s < int'(NumSrc); s++) begin
            if (push[s]) begin
                fifo_rd_q[s][wptr_q[s]]   <= in_rd[s];
                fifo_data_q[s][wptr_q[s]] <= in_data[s];
            end
        end
    end

    // Write stage and round-robin history; after reset the ALU wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
            last_q      <= SrcLsu;
        end else begin
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
            last_q      <= last_d;
        end
    end

    // Busy: every occupied FIFO slot plus the active write stage, from state only.
    always_comb begin
        busy_vec = '0;
        for (int s = 0; s < int'(NumSrc); s++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CntW'(i) < cnt_q[s]) begin
                    busy_vec[fifo_rd_q[s][PtrW'(rptr_q[s] + PtrW'(i))]] = 1'b1;
                end
            end
        end
        if (regwrite_q) begin
            busy_vec[writereg_q] = 1'b1;
        end
        busy_vec[0] = 1'b0;
    end

    assign busy      = busy_vec;
    assign regwrite  = regwrite_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a directed per-cycle vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2;

    logic              clock;
    logic              reset_n;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid, lsu_ready;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic [ADDR_W-1:0] writereg;
    logic [DATA_W-1:0] writedata;
    logic              regwrite;
    logic [31:0]       busy;

    regfile_wb_arbiter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .writereg  (writereg),
        .writedata (writedata),
        .regwrite  (regwrite),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One row = inputs held for one cycle plus the outputs expected in that
    // cycle (before the edge that consumes those inputs).
    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ear;
        logic        elr;
        logic        erw;
        logic [4:0]  ewreg;
        logic [31:0] ewdata;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] b(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    function automatic vec_t mk(
        input logic rst_n, input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic ear, input logic elr, input logic erw, input logic [4:0] ewreg,
        input logic [31:0] ewdata, input logic [31:0] ebusy);
        vec_t v;
        v.rst_n = rst_n; v.av = av; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.ear = ear; v.elr = elr; v.erw = erw; v.ewreg = ewreg;
        v.ewdata = ewdata; v.ebusy = ebusy;
        return v;
    endfunction

    // Reference model state.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq_a[$];
    ent_t        mq_l[$];
    logic        m_rw;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic        m_last_lsu;

    task automatic model_reset();
        mq_a.delete();
        mq_l.delete();
        m_rw       = 1'b0;
        m_wreg     = '0;
        m_wdata    = '0;
        m_last_lsu = 1'b1;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] bv;
        bv = '0;
        foreach (mq_a[i]) bv |= b(int'(mq_a[i].rd));
        foreach (mq_l[i]) bv |= b(int'(mq_l[i].rd));
        if (m_rw) bv |= b(int'(m_wreg));
        bv[0] = 1'b0;
        return bv;
    endfunction

    initial begin
        logic        a_pend, l_pend;
        logic [4:0]  a_rd, l_rd;
        logic [31:0] a_data, l_data;
        logic        r_rst;
        logic        exp_ar, exp_lr, ga, gl;
        int          lsu_pct;
        ent_t        e;

        // Directed sequence: reset, single write, contention, backpressure,
        // x0 write, reset with buffered writes, first tie after reset.
        vecs.push_back(mk(0, 1, 3, 32'h33, 0, 0, 0,               0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 32'h33, 0, 0, 0,               0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,         1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 0, 0, 0, b(5)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 1, 5, 32'hDEADBEEF, b(5)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 0, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 1, 0, 32'h1234, 0, 0, 0,             1, 1, 0, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 0, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 1, 1, 32'hA0000001, 1, 17, 32'hB0000001,
                          1, 1, 0, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 1, 2, 32'hA0000002, 1, 18, 32'hB0000002,
                          1, 1, 0, 5, 32'hDEADBEEF, b(1) | b(17)));
        vecs.push_back(mk(1, 1, 3, 32'hA0000003, 1, 19, 32'hB0000003,
                          0, 1, 1, 17, 32'hB0000001, b(1) | b(2) | b(17) | b(18)));
        vecs.push_back(mk(1, 1, 3, 32'hA0000003, 0, 0, 0,
                          1, 0, 1, 1, 32'hA0000001, b(1) | b(2) | b(18) | b(19)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,
                          0, 1, 1, 18, 32'hB0000002, b(2) | b(3) | b(18) | b(19)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,
                          1, 1, 1, 2, 32'hA0000002, b(2) | b(3) | b(19)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,
                          1, 1, 1, 19, 32'hB0000003, b(3) | b(19)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,
                          1, 1, 1, 3, 32'hA0000003, b(3)));
        vecs.push_back(mk(1, 1, 7, 32'hC0000007, 1, 8, 32'hD0000008,
                          1, 1, 0, 3, 32'hA0000003, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,
                          0, 0, 0, 3, 32'hA0000003, b(7) | b(8)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 9, 32'hE0000009, 1, 10, 32'hF000000A,
                          1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 0, 0, 0, b(9) | b(10)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,
                          1, 1, 1, 9, 32'hE0000009, b(9) | b(10)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 1, 10, 32'hF000000A, b(10)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,                    1, 1, 0, 10, 32'hF000000A, 0));

        reset_n   = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            reset_n   = vecs[i].rst_n;
            alu_valid = vecs[i].av;
            alu_rd    = vecs[i].ard;
            alu_data  = vecs[i].ad;
            lsu_valid = vecs[i].lv;
            lsu_rd    = vecs[i].lrd;
            lsu_data  = vecs[i].ld;
            @(negedge clock);
            check($sformatf("row%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].ear));
            check($sformatf("row%0d lsu_ready", i), 64'(lsu_ready), 64'(vecs[i].elr));
            check($sformatf("row%0d regwrite", i),  64'(regwrite),  64'(vecs[i].erw));
            check($sformatf("row%0d writereg", i),  64'(writereg),  64'(vecs[i].ewreg));
            check($sformatf("row%0d writedata", i), 64'(writedata), 64'(vecs[i].ewdata));
            check($sformatf("row%0d busy", i),      64'(busy),      64'(vecs[i].ebusy));
            @(posedge clock);
            #1;
        end

        // Randomized traffic against the reference model, starting from reset.
        reset_n   = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        a_pend = 1'b0; l_pend = 1'b0;
        a_rd = '0; l_rd = '0; a_data = '0; l_data = '0;
        lsu_pct = 50;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) lsu_pct = int'($urandom_range(10, 100));
            r_rst = ($urandom_range(0, 99) != 0) || (cyc < 2) ? (cyc >= 2) : 1'b0;
            if (!a_pend && ($urandom_range(0, 99) < 75)) begin
                a_pend = 1'b1;
                a_rd   = 5'($urandom_range(0, 31));
                a_data = $urandom;
            end
            if (!l_pend && (int'($urandom_range(0, 99)) < lsu_pct)) begin
                l_pend = 1'b1;
                l_rd   = 5'($urandom_range(0, 31));
                l_data = $urandom;
            end
            reset_n   = r_rst;
            alu_valid = a_pend;
            alu_rd    = a_rd;
            alu_data  = a_data;
            lsu_valid = l_pend;
            lsu_rd    = l_rd;
            lsu_data  = l_data;

            @(negedge clock);
            exp_ar = r_rst && (mq_a.size() < int'(DEPTH));
            exp_lr = r_rst && (mq_l.size() < int'(DEPTH));
            check($sformatf("rnd%0d alu_ready", cyc), 64'(alu_ready), 64'(exp_ar));
            check($sformatf("rnd%0d lsu_ready", cyc), 64'(lsu_ready), 64'(exp_lr));
            check($sformatf("rnd%0d regwrite", cyc),  64'(regwrite),  64'(m_rw));
            check($sformatf("rnd%0d writereg", cyc),  64'(writereg),  64'(m_wreg));
            check($sformatf("rnd%0d writedata", cyc), 64'(writedata), 64'(m_wdata));
            check($sformatf("rnd%0d busy", cyc),      64'(busy),      64'(model_busy()));

            // Advance the model across the coming edge.
            if (!r_rst) begin
                model_reset();
            end else begin
                ga = (mq_a.size() > 0) && ((mq_l.size() == 0) || m_last_lsu);
                gl = (mq_l.size() > 0) && !ga;
                if (ga) begin
                    e = mq_a.pop_front();
                    m_rw = 1'b1; m_wreg = e.rd; m_wdata = e.data; m_last_lsu = 1'b0;
                end else if (gl) begin
                    e = mq_l.pop_front();
                    m_rw = 1'b1; m_wreg = e.rd; m_wdata = e.data; m_last_lsu = 1'b1;
                end else begin
                    m_rw = 1'b0;
                end
                if (a_pend && exp_ar && (a_rd != '0)) begin
                    e.rd = a_rd; e.data = a_data;
                    mq_a.push_back(e);
                end
                if (l_pend && exp_lr && (l_rd != '0)) begin
                    e.rd = l_rd; e.data = l_data;
                    mq_l.push_back(e);
                end
            end
            if (a_pend && exp_ar) a_pend = 1'b0;
            if (l_pend && exp_lr) l_pend = 1'b0;

            @(posedge clock);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
